// File: rtl/curve_lut_ctrl.sv
// Double-buffered 8-bit grey-level contrast-curve lookup controller.
// Holds two 256x8 curve banks. One bank maps pixels while the host loads the
// other. A commit swaps the two banks at the next frame boundary, which is a
// rising edge of vsync.
//
//  state      | meaning
//  -----------+---------------------------------------------------------------
//  ST_INIT    | both banks being filled after reset, pixels bypass the lookup
//  ST_IDLE    | lookup live, host may write the shadow bank and commit
//  ST_PENDING | commit accepted, waiting for a vsync rising edge to swap banks
module curve_lut_ctrl #(
  parameter int INIT_IDENTITY = 1
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,

  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,

  input  logic       cfg_wr_en,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       cfg_commit,
  output logic       cfg_ready,
  output logic       cfg_pending,
  output logic       cfg_err,
  output logic       active_bank
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] init_cnt;

  logic [7:0] bank0 [256];
  logic [7:0] bank1 [256];

  logic       vsync_rise;
  logic       swap;
  logic       init_we;
  logic       shadow_we;
  logic       wr_reject;
  logic [7:0] fill_val;
  logic [7:0] lut_rd;

  // post_frame_vsync is the registered copy of vsync, so it doubles as the
  // previous-cycle value for frame-boundary detection.
  assign vsync_rise = per_frame_vsync & ~post_frame_vsync;

  assign fill_val = (INIT_IDENTITY != 0) ? init_cnt : 8'd0;

  // Read the active bank with the bank index held at the sampling edge.
  assign lut_rd = active_bank ? bank1[per_img_Y] : bank0[per_img_Y];

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    init_we   = 1'b0;
    shadow_we = 1'b0;
    wr_reject = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_cnt == 8'hFF) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A write in the commit cycle still lands before the commit is taken.
        shadow_we = cfg_wr_en;
        if (cfg_commit) begin
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        wr_reject = cfg_wr_en;
        if (vsync_rise) begin
          swap      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Control registers: state, init counter, bank select and host status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      init_cnt    <= 8'd0;
      active_bank <= 1'b0;
      cfg_ready   <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (init_we) begin
        init_cnt <= init_cnt + 8'd1;
      end
      if (swap) begin
        active_bank <= ~active_bank;
      end
      cfg_ready   <= (state_nxt == ST_IDLE);
      cfg_pending <= (state_nxt == ST_PENDING);
      cfg_err     <= wr_reject;
    end
  end

  // Pixel path: one register stage, bypass while the banks are being filled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Y       <= 8'd0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_Y       <= (state == ST_INIT) ? per_img_Y : lut_rd;
    end
  end

  // Bank write port: init fills both banks, host writes only the shadow bank.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (init_we) begin
        bank0[init_cnt] <= fill_val;
        bank1[init_cnt] <= fill_val;
      end else if (shadow_we) begin
        if (active_bank) begin
          bank0[cfg_addr] <= cfg_data;
        end else begin
          bank1[cfg_addr] <= cfg_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_curve_lut_ctrl.sv
// Directed bench for curve_lut_ctrl with a behavioural curve model checked
// every cycle plus hand-computed literal expectations.
module tb_curve_lut_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] per_img_Y = 8'd0;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_Y;
  logic       cfg_wr_en = 1'b0;
  logic [7:0] cfg_addr = 8'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       cfg_commit = 1'b0;
  logic       cfg_ready;
  logic       cfg_pending;
  logic       cfg_err;
  logic       active_bank;

  int n_tests = 0;
  int n_fail  = 0;

  curve_lut_ctrl #(.INIT_IDENTITY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Y(per_img_Y),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Y(post_img_Y),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .cfg_pending(cfg_pending),
    .cfg_err(cfg_err), .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_curve [2][256];
  bit   m_live = 0;
  bit   m_filling;
  int   m_fill_left;
  bit   m_active;
  bit   m_pending;
  bit   m_vs_prev;
  logic [7:0] e_y;
  bit   e_v, e_h, e_c, e_ready, e_pend, e_err, e_active;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1; m_filling = 1; m_fill_left = 256;
      m_active = 0; m_pending = 0; m_vs_prev = 0;
      e_y = 0; e_v = 0; e_h = 0; e_c = 0;
      e_ready = 0; e_pend = 0; e_err = 0; e_active = 0;
    end else if (m_live) begin
      e_err = 0;
      if (m_filling) begin
        e_y = per_img_Y;
        m_curve[0][256 - m_fill_left] = 8'(256 - m_fill_left);
        m_curve[1][256 - m_fill_left] = 8'(256 - m_fill_left);
        m_fill_left--;
        if (m_fill_left == 0) m_filling = 0;
      end else begin
        e_y = m_curve[m_active][per_img_Y];
        if (m_pending) begin
          if (cfg_wr_en) e_err = 1;
          if (per_frame_vsync && !m_vs_prev) begin
            m_active = !m_active;
            m_pending = 0;
          end
        end else begin
          if (cfg_wr_en) m_curve[!m_active][cfg_addr] = cfg_data;
          if (cfg_commit) m_pending = 1;
        end
      end
      m_vs_prev = per_frame_vsync;
      e_v = per_frame_vsync; e_h = per_frame_href; e_c = per_frame_clken;
      e_ready = !m_filling && !m_pending;
      e_pend = m_pending;
      e_active = m_active;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_vsync", {7'd0, post_frame_vsync}, {7'd0, e_v});
      chk("m_href",  {7'd0, post_frame_href},  {7'd0, e_h});
      chk("m_clken", {7'd0, post_frame_clken}, {7'd0, e_c});
      chk("m_ready", {7'd0, cfg_ready},        {7'd0, e_ready});
      chk("m_pend",  {7'd0, cfg_pending},      {7'd0, e_pend});
      chk("m_err",   {7'd0, cfg_err},          {7'd0, e_err});
      chk("m_bank",  {7'd0, active_bank},      {7'd0, e_active});
      if (e_c) chk("m_pixel", post_img_Y, e_y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_init(input string name);
    int cnt;
    cnt = 0;
    per_frame_clken = 1'b1;
    while (1) begin
      per_img_Y = 8'(cnt);
      step();
      cnt++;
      if (cnt == 11) chk({name, "_bypass"}, post_img_Y, 8'd10);
      if (cnt == 255) chk({name, "_not_ready"}, {7'd0, cfg_ready}, 8'd0);
      if (cfg_ready === 1'b1) break;
      if (cnt >= 400) break;
    end
    chk({name, "_len"}, 8'(cnt == 256), 8'd1);
  endtask

  task automatic pix(input logic [7:0] y);
    per_img_Y = y;
    step();
  endtask

  task automatic vs_pulse();
    per_frame_vsync = 1'b1;
    step();
    per_frame_vsync = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", {7'd0, cfg_ready}, 8'd0);
    chk("rst_pend",  {7'd0, cfg_pending}, 8'd0);
    chk("rst_bank",  {7'd0, active_bank}, 8'd0);
    chk("rst_err",   {7'd0, cfg_err}, 8'd0);
    chk("rst_y",     post_img_Y, 8'd0);
    chk("rst_clken", {7'd0, post_frame_clken}, 8'd0);

    rst_n = 1'b1;
    run_init("init");

    per_frame_href = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pix(8'(i));
      if (i == 8'h37) chk("ident_37", post_img_Y, 8'h37);
    end

    // Inverse curve into the shadow bank, commit, then a frame boundary.
    cfg_wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cfg_addr = 8'(i);
      cfg_data = 8'(255 - i);
      step();
    end
    cfg_wr_en = 1'b0;
    pix(8'h80);
    chk("inv_before", post_img_Y, 8'h80);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("commit_pend", {7'd0, cfg_pending}, 8'd1);
    chk("commit_rdy",  {7'd0, cfg_ready}, 8'd0);
    vs_pulse();
    chk("inv_bank", {7'd0, active_bank}, 8'd1);
    pix(8'h00); chk("inv_00", post_img_Y, 8'hFF);
    pix(8'h80); chk("inv_80", post_img_Y, 8'h7F);
    pix(8'hFF); chk("inv_ff", post_img_Y, 8'h00);

    // Commit mid-frame: old curve stays until the vsync edge.
    per_img_Y = 8'h20;
    step(); step();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step(); step();
    chk("mid_old", post_img_Y, 8'hDF);
    chk("mid_pend", {7'd0, cfg_pending}, 8'd1);
    per_frame_vsync = 1'b1;
    step();
    chk("mid_edge_old", post_img_Y, 8'hDF);
    per_frame_vsync = 1'b0;
    step();
    chk("mid_new", post_img_Y, 8'h20);
    chk("mid_pend_clr", {7'd0, cfg_pending}, 8'd0);
    chk("mid_bank", {7'd0, active_bank}, 8'd0);

    // Write while pending is rejected.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 8'h10; cfg_data = 8'h55;
    step();
    cfg_wr_en = 1'b0;
    chk("err_pulse", {7'd0, cfg_err}, 8'd1);
    step();
    chk("err_clear", {7'd0, cfg_err}, 8'd0);
    vs_pulse();
    pix(8'h10);
    chk("err_entry_kept", post_img_Y, 8'hEF);

    // Write and commit in the same cycle.
    cfg_wr_en = 1'b1; cfg_commit = 1'b1; cfg_addr = 8'h40; cfg_data = 8'hAA;
    step();
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    vs_pulse();
    pix(8'h40);
    chk("wc_40", post_img_Y, 8'hAA);
    pix(8'h41);
    chk("wc_41", post_img_Y, 8'h41);

    // vsync edge without a commit, then commit while vsync is held high.
    per_frame_vsync = 1'b1;
    repeat (3) step();
    chk("vs_noop_bank", {7'd0, active_bank}, 8'd0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    repeat (4) step();
    chk("vs_held_bank", {7'd0, active_bank}, 8'd0);
    chk("vs_held_pend", {7'd0, cfg_pending}, 8'd1);
    vs_pulse();
    vs_pulse();
    chk("vs_one_swap", {7'd0, active_bank}, 8'd1);

    // Reset during PENDING discards the commit and reruns init.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rp_pend", {7'd0, cfg_pending}, 8'd0);
    chk("rp_bank", {7'd0, active_bank}, 8'd0);
    chk("rp_ready", {7'd0, cfg_ready}, 8'd0);
    run_init("reinit");
    pix(8'h40); chk("rp_ident_40", post_img_Y, 8'h40);
    pix(8'h10); chk("rp_ident_10", post_img_Y, 8'h10);
    pix(8'hFF); chk("rp_ident_ff", post_img_Y, 8'hFF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/curve_lut_ctrl.md
# curve_lut_ctrl

Double-buffered controller for the 8-bit grey-level contrast-curve lookup stage. It owns two 256×8 curve banks, initialises them after reset, and accepts a new curve from a configuration port into the shadow bank. On commit it swaps banks only at a frame boundary. Every pixel of a frame is therefore mapped by exactly one curve. It sits inline in the video stream between the Y-extraction stage and downstream processing, and replaces a fixed constant curve table.

## Interface
- INIT_IDENTITY, 1: fill value for both banks during post-reset init. 1 = identity (entry n = n); 0 = all zero.
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- per_frame_vsync  in  1  input frame sync; a rising edge marks the frame boundary.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel valid.
- per_img_Y  in  8  input grey pixel.
- post_frame_vsync  out  1  per_frame_vsync delayed 1 cycle.
- post_frame_href  out  1  per_frame_href delayed 1 cycle.
- post_frame_clken  out  1  per_frame_clken delayed 1 cycle.
- post_img_Y  out  8  mapped pixel.
- cfg_wr_en  in  1  write cfg_data into the shadow bank at cfg_addr.
- cfg_addr  in  8  curve entry index (input grey level).
- cfg_data  in  8  curve output value.
- cfg_commit  in  1  single-cycle request to activate the shadow bank.
- cfg_ready  out  1  high = shadow writes and commit accepted.
- cfg_pending  out  1  high = commit waiting for a frame boundary.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- active_bank  out  1  index of the bank currently used for lookup.

## Operation
- State machine: INIT → IDLE ⇄ PENDING.
- Reset (rst_n low at a clk edge) sets: state INIT, init_cnt 0, active_bank 0, cfg_ready 0, cfg_pending 0, cfg_err 0, and all post_* outputs 0.
- INIT:
  - Each cycle writes fill value (init_cnt, or 0) to address init_cnt in both banks, then increments init_cnt.
  - After the write at init_cnt 255, the next state is IDLE.
  - INIT lasts exactly 256 cycles.
  - cfg inputs are ignored with no cfg_err.
  - Pixel path is bypass: post_img_Y = per_img_Y registered.
- IDLE:
  - cfg_ready 1.
  - cfg_wr_en writes bank[~active_bank][cfg_addr] = cfg_data.
  - cfg_commit moves to PENDING. cfg_ready drops to 0 and cfg_pending rises to 1 on the next cycle.
  - cfg_wr_en and cfg_commit in the same cycle: the write is performed, then the commit is taken.
- PENDING:
  - Waits for a vsync rising edge (per_frame_vsync 1 with the registered previous value 0).
  - cfg_wr_en is rejected (shadow unchanged) and cfg_err pulses high the following cycle.
  - Repeat cfg_commit is ignored.
  - On the edge cycle, active_bank toggles, state → IDLE, cfg_pending → 0, cfg_ready → 1 (all visible next cycle).
- The swap copies nothing. The new shadow bank holds the previous curve; the host rewrites whichever entries it needs.
- Lookup (after INIT): post_img_Y = bank[active_bank][per_img_Y], using the active_bank value held at the sampling edge.
  - The lookup is performed every cycle regardless of clken.
  - post_img_Y is only meaningful when post_frame_clken = 1.
- Each bank is one write port (init or cfg) and one read port (pixel). Shadow writes never disturb active-bank reads.
- Reset mid-INIT or mid-PENDING: any pending commit is discarded, INIT restarts, and both banks are refilled.

## Timing
- Pixel latency: exactly 1 cycle from per_* to post_*, in both bypass and lookup modes.
- Throughput: 1 pixel/cycle, with no stall.
- Init: cfg_ready first reads 1 on the 257th cycle after the first clk edge with rst_n high.
- Commit-to-swap: from 1 cycle up to a full frame. The new curve applies from the first pixel sampled after the vsync edge cycle.
- cfg write: shadow entry updated at the clk edge where cfg_wr_en is sampled high in IDLE.
- vsync edge in IDLE with no commit: no action.
- vsync held high: at most one swap per rising edge.

## Test plan
- Reset, then a 256-value ramp on per_img_Y during INIT → post_img_Y equals the input 1 cycle later. cfg_ready goes 1 at cycle 257. With INIT_IDENTITY=1, the post-INIT ramp still maps n → n.
- Write the inverse curve (entry n = 255−n) in IDLE, commit, assert the vsync edge, then feed 0x00/0x80/0xFF → 0xFF/0x7F/0x00 with latency 1. active_bank reads 1.
- Commit mid-frame with pixels flowing → output stays on the old curve until the vsync rising edge. cfg_pending is 1 throughout, then clears.
- cfg_wr_en to addr 0x10 while PENDING → cfg_err pulses once. After the swap, the old entry 0x10 is unchanged in the new active bank.
- cfg_wr_en and cfg_commit in the same cycle (addr 0x40, data 0xAA) → after the swap, input 0x40 maps to 0xAA.
- rst_n low for one cycle during PENDING → cfg_pending 0, active_bank 0, INIT reruns for 256 cycles, and output returns to the identity curve.
